// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter for a pipelined Avalon-MM style memory port.
// Master 0 is the CPU, master 1 a loader/DMA engine. The grant is held while the
// slave stalls, and read-return IDs are kept in issue order so that each
// rddatavalid beat is routed back to the master that issued the read.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (m0 wins every
// conflict); the default build is round-robin.
module mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_m0_addr,
    input  logic [15:0] i_m1_addr,
    input  logic [15:0] i_m0_wrdata,
    input  logic [15:0] i_m1_wrdata,
    input  logic        i_m0_rd,
    input  logic        i_m1_rd,
    input  logic        i_m0_wr,
    input  logic        i_m1_wr,
    output logic        o_m0_wait,
    output logic        o_m1_wait,
    output logic [15:0] o_m0_rddata,
    output logic [15:0] o_m1_rddata,
    output logic        o_m0_rddatavalid,
    output logic        o_m1_rddatavalid,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wrdata,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    input  logic        i_mem_wait,
    input  logic [15:0] i_mem_rddata,
    input  logic        i_mem_rddatavalid,
    output logic        o_err
);

    localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                     state_q, state_d;
    logic                       lock_id_q, lock_id_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]            count_q;
    logic                       err_q;

    logic [1:0] req, is_wr, is_rd, elig, accepted;
    logic       full, empty, gnt_valid, gnt_id, accept, push, pop, head;

    // A request with both strobes set is a write; rd is ignored.
    assign req   = {i_m1_rd | i_m1_wr, i_m0_rd | i_m0_wr};
    assign is_wr = {i_m1_wr, i_m0_wr};
    assign is_rd = req & ~is_wr;
    assign full  = (count_q == CntW'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);
    // Reads need a free ID slot; writes never wait on the FIFO.
    assign elig  = is_wr | (is_rd & {2{~full}});

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic last_q;
`endif

    // Grant selection: arbitrate in IDLE, hold the stalled master in LOCKED.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (elig[0] && elig[1]) begin
                    gnt_valid = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
                    gnt_id    = 1'b0;
`else
                    gnt_id    = ~last_q;
`endif
                end else if (elig[0]) begin
                    gnt_valid = 1'b1;
                end else if (elig[1]) begin
                    gnt_valid = 1'b1;
                    gnt_id    = 1'b1;
                end
            end
            StLocked: begin
                // A dropped request leaves no grant, so nothing is accepted.
                gnt_id    = lock_id_q;
                gnt_valid = elig[lock_id_q];
            end
            default: ;
        endcase
    end

    assign accept   = gnt_valid & ~i_mem_wait;
    assign accepted = accept ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    assign push     = accept & is_rd[gnt_id];
    assign pop      = i_mem_rddatavalid & ~empty;
    assign head     = fifo_q[rd_ptr_q];

    // Next state: lock on a stalled grant, release on acceptance or dropped request.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid && i_mem_wait) begin
                    state_d   = StLocked;
                    lock_id_d = gnt_id;
                end
            end
            StLocked: begin
                if (!gnt_valid || !i_mem_wait) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Slave-side mux and master-side handshake; forced safe while reset is low.
    always_comb begin
        o_mem_rd         = 1'b0;
        o_mem_wr         = 1'b0;
        o_mem_addr       = '0;
        o_mem_wrdata     = '0;
        o_m0_wait        = 1'b1;
        o_m1_wait        = 1'b1;
        o_m0_rddatavalid = 1'b0;
        o_m1_rddatavalid = 1'b0;
        if (reset) begin
            o_mem_rd         = gnt_valid & is_rd[gnt_id];
            o_mem_wr         = gnt_valid & is_wr[gnt_id];
            if (gnt_valid) begin
                o_mem_addr   = gnt_id ? i_m1_addr : i_m0_addr;
                o_mem_wrdata = gnt_id ? i_m1_wrdata : i_m0_wrdata;
            end
            o_m0_wait        = req[0] & ~accepted[0];
            o_m1_wait        = req[1] & ~accepted[1];
            o_m0_rddatavalid = pop & ~head;
            o_m1_rddatavalid = pop & head;
        end
    end

    assign o_m0_rddata = i_mem_rddata;
    assign o_m1_rddata = i_mem_rddata;
    assign o_err       = err_q;

    // Arbitration state and read-ID FIFO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            lock_id_q <= 1'b0;
            fifo_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= gnt_id;
                wr_ptr_q         <= wr_ptr_q + PtrW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop) count_q <= count_q + CntW'(1);
            else if (pop && !push) count_q <= count_q - CntW'(1);
            if (i_mem_rddatavalid && empty) err_q <= 1'b1;
        end
    end

`ifndef MEM_ARB_FIXED_PRIO_EN
    // Round-robin pointer: master served by the last accepted transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= gnt_id;
        end
    end
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the single pipelined memory port (Avalon-MM style: `rd`/`wr`, `wait`, `rddatavalid`) between the CPU (master 0) and a second requester such as a program loader or DMA engine (master 1). It selects one master per transfer and holds the grant while the slave stalls. It tracks outstanding reads in issue order so each `rddatavalid` beat is returned to the master that issued it. It sits between `cpu` and the memory/interconnect.

## Interface
Parameters:
- `MAX_OUTSTANDING`, 4, depth of the read-return ID FIFO; power of two, 2–16.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `i_m0_addr`, `i_m1_addr`  in  16  master request address.
- `i_m0_wrdata`, `i_m1_wrdata`  in  16  master write data.
- `i_m0_rd`, `i_m1_rd`  in  1  read request.
- `i_m0_wr`, `i_m1_wr`  in  1  write request.
- `o_m0_wait`, `o_m1_wait`  out  1  request not accepted this cycle.
- `o_m0_rddata`, `o_m1_rddata`  out  16  returned read data; `i_mem_rddata` fanned out.
- `o_m0_rddatavalid`, `o_m1_rddatavalid`  out  1  read-return strobe for that master.
- `o_mem_addr`, `o_mem_wrdata`  out  16  slave-side muxed request.
- `o_mem_rd`, `o_mem_wr`  out  1  slave-side strobes.
- `i_mem_wait`  in  1  slave stall.
- `i_mem_rddata`  in  16  slave read data.
- `i_mem_rddatavalid`  in  1  slave read-return strobe.
- `o_err`  out  1  sticky: `rddatavalid` arrived with no read outstanding.

## Operation
- Request per master: `reqX = i_mX_rd | i_mX_wr`. If both strobes are set, the request is treated as a write; `rd` is ignored.
- Read eligibility: a read request is eligible only when the FIFO is not full. Writes are always eligible.
- State `IDLE`:
  - Grant the sole eligible requester.
  - On conflict, grant the master not served by the last accepted transfer. The round-robin pointer `last` resets to 1, so m0 wins first.
- State `LOCKED(id)`: entered when the granted transfer sees `i_mem_wait=1`.
  - Grant is held on `id` regardless of other requests.
  - Returns to `IDLE` on the cycle the transfer is accepted.
- Acceptance is `grant & req & ~i_mem_wait` in one cycle. On acceptance, `last` ← granted id. A read acceptance also pushes the id into the FIFO.
- Slave outputs are combinational from the granted master: `o_mem_rd`, `o_mem_wr`, address and data. With no grant, strobes are 0 and address/data are 0.
- `o_mX_wait = reqX & ~acceptedX`. The non-granted requester, or a read blocked by a full FIFO, sees wait=1.
- Read return:
  - `i_mem_rddatavalid` pops the FIFO head and asserts `o_m<head>_rddatavalid` in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop with the FIFO empty: no strobe forwarded, `o_err`←1 until reset.
- A master dropping its request while LOCKED is a protocol violation. The arbiter drops the lock, returns to `IDLE` and accepts nothing.

## Timing
- Zero-cycle request latency: a master request appears on the slave port in the same cycle.
- Read-return routing is combinational (0 cycles).
- State, `last`, FIFO pointers/count and `o_err` are registered and update on `clk` rise.
- Reset (asynchronous assert, synchronous-safe release):
  - State `IDLE`, `last`=1, FIFO empty, `o_err`=0.
  - While reset is low: `o_mem_rd`=`o_mem_wr`=0, both `o_mX_wait`=1, both `o_mX_rddatavalid`=0.
- Reset mid-transfer discards outstanding read IDs. Later returns then raise `o_err`.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined: fixed priority. m0 always wins a conflict, and `last` is not implemented.
- Undefined (default): round-robin as described above.
- The LOCKED behaviour is identical in both builds.

## Test plan
- **Single read:** m0 reads 0x0010 with the slave returning 0xBEEF two cycles later. Required: `o_mem_rd`=1 with addr 0x0010 in cycle 0, `o_m0_wait`=0; `o_m0_rddatavalid`=1 with data 0xBEEF in cycle 2; m1 strobe stays 0.
- **Contention:** both masters issue continuous writes with no slave stall. Required: grants m0, m1, m0, m1; the losing master sees wait=1 each cycle. Under `MEM_ARB_FIXED_PRIO_EN`, m0 is granted every cycle.
- **Stall lock:** m1 is granted and `i_mem_wait`=1 for 3 cycles while m0 requests. Required: address stays on m1's address for 4 cycles, m0 wait=1 throughout; m0 is granted the cycle after acceptance.
- **FIFO full:** m0 issues 4 reads with no returns, then a 5th read while m1 writes. Required: the 5th read sees wait=1 and the m1 write is accepted. One `rddatavalid` releases the 5th read the following cycle.
- **Interleaved returns and error:** reads issued m0, m1, m0, then 3 returns of 0x1111, 0x2222, 0x3333. Required: these route to m0, m1, m0 respectively. A 4th spurious return sets `o_err`=1, and it stays 1.
- **Reset mid-operation:** `reset`=0 during a LOCKED stall with 2 reads outstanding. Required: strobes are 0 immediately; after release the FIFO is empty, `o_err`=0, and m0 wins the first conflict.
